mor1kx_spr_sysgrp: RTL and testbench
====================================

// Module: mor1kx_spr_sysgrp
// PURPOSE
//  SPR-bus responder for SPR group 0: the access side of the read-only configuration registers.
//  Accepts mfspr/mtspr requests from the SPR bus master and returns the configuration word values.
//  Holds the writable group-0 registers EVBAR, AECR and AESR, and returns ack after a fixed wait-state count.
//  Sits in the control unit, beside the configuration-register source.
// PARAMETERS
//  FEATURE_EVBAR      "NONE"  "ENABLED" implements EVBAR; otherwise it reads as 0 and ignores writes
//  FEATURE_AECSR      "NONE"  "ENABLED" implements AECR/AESR; otherwise both read as 0 and ignore writes
//  OPTION_WAIT_STATES 0       extra cycles between request accept and ack (0..15)
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous reset, active-high
//  spr_bus_stb_i  in   1   request strobe; held high until ack
//  spr_bus_we_i   in   1   1=write (mtspr), 0=read (mfspr)
//  spr_bus_addr_i in   16  SPR address; [15:11]=group, [10:0]=index
//  spr_bus_dat_i  in   32  write data
//  spr_bus_dat_o  out  32  read data, valid only while ack=1
//  spr_bus_ack_o  out  1   one-cycle access-complete pulse
//  spr_cfg_i      in   352 {avr,vr2,pccfgr,dcfgr,iccfgr,dccfgr,immucfgr,dmmucfgr,cpucfgr,upr,vr}, 32b each, LSW=vr
//  aesr_set_i     in   7   hardware arithmetic-exception event bits, sticky-set into AESR
//  spr_evbar_o    out  32  current EVBAR
//  spr_aecr_o     out  7   current AECR
//  spr_aesr_o     out  7   current AESR
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ack=0, dat_o=0, EVBAR=0, AECR=0, AESR=0, wait counter=0.
//  Claim: a request is claimed only if stb=1 and addr[15:11]==0. Other groups are never acked.
//  State machine:
//   IDLE: on a claimed request, latch addr/we/dat. Go to WAIT if OPTION_WAIT_STATES>0, else to ACK.
//   WAIT: counter loads OPTION_WAIT_STATES-1 and decrements; go to ACK when it reaches 0.
//   ACK: ack=1 for exactly this cycle. The write commits at the ACK cycle edge. Always return to IDLE.
//  Latency: stb rises at cycle N; ack is high in cycle N+1+OPTION_WAIT_STATES.
//  Master drops stb in the cycle after ack. stb high in IDLE is a new request, so back-to-back accesses are legal.
//  stb dropping before ack: the access still completes (ack pulses) and the master ignores it.
//  Read map (index -> data), registered into dat_o on entry to ACK, and 0 outside ACK:
//   0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR,
//   8 PCCFGR, 9 VR2, 10 AVR, 11 EVBAR, 12 {25'b0,AECR}, 13 {25'b0,AESR}; any other index reads 0.
//  Writes:
//   EVBAR: bits [31:13] take data, [12:0] forced 0.
//   AECR: takes data[6:0].
//   AESR: takes data[6:0] | aesr_set_i.
//   Indices 0-10 and unmapped indices are acked with no state change (no error signalled).
//  AESR sticky: AESR <= AESR | aesr_set_i every cycle. A hardware set in the same cycle as a SW write wins per bit.
//  Config inputs are sampled at ACK entry; changes mid-access are not required to be visible.
//  Reset mid-access: ack is dropped immediately, the pending write is discarded, and state returns to IDLE.
// TESTING
//  1. WAIT_STATES=0, read idx 0 with spr_cfg_i vr=32'h0000_0010 -> ack at N+1 with dat_o=32'h0000_0010; ack low at N+2.
//  2. FEATURE_EVBAR="ENABLED", write idx 11 data 32'hDEAD_BEEF, then read idx 11 -> spr_evbar_o=32'hDEAD_A000 and read returns the same.
//  3. FEATURE_AECSR="ENABLED": aesr_set_i=7'h04 pulsed, then SW write AESR=7'h01 while aesr_set_i=7'h10 -> AESR=7'h11 (bit 2 cleared by the write, bit 4 set).
//  4. WAIT_STATES=3: read idx 2 -> ack exactly 4 cycles after stb. Request to addr 16'h0800 (group 1) -> no ack for 20 cycles.
//  5. rst asserted in the WAIT cycle of a write to AECR=7'h7F -> ack never rises, AECR=0, and the next read of idx 12 returns 0.
//  6. Back-to-back: read idx 9 then write idx 1 with no idle gap -> two ack pulses; idx 1 read still returns the UPR input value.

Source files
------------

// File: rtl/mor1kx_spr_sysgrp.sv
// SPR group 0 responder: serves the read-only configuration words and owns the writable
// EVBAR/AECR/AESR registers, acking each claimed access after a fixed number of wait states.
module mor1kx_spr_sysgrp #(
   parameter string       FEATURE_EVBAR      = "NONE",
   parameter string       FEATURE_AECSR      = "NONE",
   parameter int unsigned OPTION_WAIT_STATES = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         spr_bus_stb_i,
   input  logic         spr_bus_we_i,
   input  logic [15:0]  spr_bus_addr_i,
   input  logic [31:0]  spr_bus_dat_i,
   output logic [31:0]  spr_bus_dat_o,
   output logic         spr_bus_ack_o,
   input  logic [351:0] spr_cfg_i,
   input  logic [6:0]   aesr_set_i,
   output logic [31:0]  spr_evbar_o,
   output logic [6:0]   spr_aecr_o,
   output logic [6:0]   spr_aesr_o
);

   localparam bit         EvbarEn  = (FEATURE_EVBAR == "ENABLED");
   localparam bit         AecsrEn  = (FEATURE_AECSR == "ENABLED");
   localparam bit         HasWait  = (OPTION_WAIT_STATES != 0);
   localparam logic [3:0] WaitLoad = HasWait ? 4'(OPTION_WAIT_STATES - 1) : 4'd0;

   localparam logic [10:0] IdxEvbar = 11'd11;
   localparam logic [10:0] IdxAecr  = 11'd12;
   localparam logic [10:0] IdxAesr  = 11'd13;

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [10:0] idx_q;
   logic        we_q;
   logic [18:0] wdat_hi_q;
   logic [6:0]  wdat_lo_q;
   logic [31:0] dat_q;
   logic [31:0] evbar_q;
   logic [6:0]  aecr_q;
   logic [6:0]  aesr_q;

   logic        claim;
   logic        commit;
   logic [10:0] rd_idx;
   logic [31:0] rd_data;
   logic        unused_dat;

   // Only EVBAR[31:13] and the 7-bit AECR/AESR fields are ever written.
   assign unused_dat = ^spr_bus_dat_i[12:7];

   assign claim  = spr_bus_stb_i && (spr_bus_addr_i[15:11] == 5'd0);
   assign commit = (state_q == StAck) && we_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (claim) begin
               if (HasWait) begin
                  state_d = StWait;
                  cnt_d   = WaitLoad;
               end else begin
                  state_d = StAck;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StAck;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StAck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      spr_bus_ack_o = (state_q == StAck);
      spr_bus_dat_o = (state_q == StAck) ? dat_q : 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= 11'd0;
         we_q      <= 1'b0;
         wdat_hi_q <= 19'd0;
         wdat_lo_q <= 7'd0;
      end else if (state_q == StIdle && claim) begin
         idx_q     <= spr_bus_addr_i[10:0];
         we_q      <= spr_bus_we_i;
         wdat_hi_q <= spr_bus_dat_i[31:13];
         wdat_lo_q <= spr_bus_dat_i[6:0];
      end
   end

   // With no wait states ACK is entered straight from IDLE, before the address is latched.
   assign rd_idx = (state_q == StIdle) ? spr_bus_addr_i[10:0] : idx_q;

   always_comb begin
      rd_data = 32'h0;
      case (rd_idx)
         11'd0:    rd_data = spr_cfg_i[31:0];
         11'd1:    rd_data = spr_cfg_i[63:32];
         11'd2:    rd_data = spr_cfg_i[95:64];
         11'd3:    rd_data = spr_cfg_i[127:96];
         11'd4:    rd_data = spr_cfg_i[159:128];
         11'd5:    rd_data = spr_cfg_i[191:160];
         11'd6:    rd_data = spr_cfg_i[223:192];
         11'd7:    rd_data = spr_cfg_i[255:224];
         11'd8:    rd_data = spr_cfg_i[287:256];
         11'd9:    rd_data = spr_cfg_i[319:288];
         11'd10:   rd_data = spr_cfg_i[351:320];
         IdxEvbar: rd_data = evbar_q;
         IdxAecr:  rd_data = {25'h0, aecr_q};
         IdxAesr:  rd_data = {25'h0, aesr_q};
         default:  rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_q <= 32'h0;
      end else if (state_d == StAck) begin
         dat_q <= rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evbar_q <= 32'h0;
      end else if (EvbarEn && commit && idx_q == IdxEvbar) begin
         evbar_q <= {wdat_hi_q, 13'h0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aecr_q <= 7'h0;
      end else if (AecsrEn && commit && idx_q == IdxAecr) begin
         aecr_q <= wdat_lo_q;
      end
   end

   // Hardware event bits are OR-ed in even on the cycle software writes AESR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aesr_q <= 7'h0;
      end else if (AecsrEn) begin
         if (commit && idx_q == IdxAesr) begin
            aesr_q <= wdat_lo_q | aesr_set_i;
         end else begin
            aesr_q <= aesr_q | aesr_set_i;
         end
      end
   end

   assign spr_evbar_o = evbar_q;
   assign spr_aecr_o  = aecr_q;
   assign spr_aesr_o  = aesr_q;

endmodule

// File: tb/tb_mor1kx_spr_sysgrp.sv
// Bench for mor1kx_spr_sysgrp: three instances (0/3/1 wait states, last with features off)
// checked every cycle against a transaction-timestamp model plus literal expectations.
module tb_mor1kx_spr_sysgrp;

   localparam int NI = 3;
   localparam int unsigned WS [NI] = '{0, 3, 1};
   localparam bit FEAT [NI] = '{1'b1, 1'b1, 1'b0};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stb [NI];
   logic         we [NI];
   logic [15:0]  addr [NI];
   logic [31:0]  wd [NI];
   logic [351:0] cfg;
   logic [6:0]   aset;

   logic [31:0]  dat_w [NI];
   logic         ack_w [NI];
   logic [31:0]  evbar_w [NI];
   logic [6:0]   aecr_w [NI];
   logic [6:0]   aesr_w [NI];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mor1kx_spr_sysgrp #(
      .FEATURE_EVBAR("ENABLED"), .FEATURE_AECSR("ENABLED"), .OPTION_WAIT_STATES(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .spr_bus_stb_i(stb[0]), .spr_bus_we_i(we[0]),
      .spr_bus_addr_i(addr[0]), .spr_bus_dat_i(wd[0]), .spr_bus_dat_o(dat_w[0]),
      .spr_bus_ack_o(ack_w[0]), .spr_cfg_i(cfg), .aesr_set_i(aset),
      .spr_evbar_o(evbar_w[0]), .spr_aecr_o(aecr_w[0]), .spr_aesr_o(aesr_w[0])
   );

   mor1kx_spr_sysgrp #(
      .FEATURE_EVBAR("ENABLED"), .FEATURE_AECSR("ENABLED"), .OPTION_WAIT_STATES(3)
   ) u_dut1 (
      .clk(clk), .rst(rst), .spr_bus_stb_i(stb[1]), .spr_bus_we_i(we[1]),
      .spr_bus_addr_i(addr[1]), .spr_bus_dat_i(wd[1]), .spr_bus_dat_o(dat_w[1]),
      .spr_bus_ack_o(ack_w[1]), .spr_cfg_i(cfg), .aesr_set_i(aset),
      .spr_evbar_o(evbar_w[1]), .spr_aecr_o(aecr_w[1]), .spr_aesr_o(aesr_w[1])
   );

   mor1kx_spr_sysgrp #(
      .FEATURE_EVBAR("NONE"), .FEATURE_AECSR("NONE"), .OPTION_WAIT_STATES(1)
   ) u_dut2 (
      .clk(clk), .rst(rst), .spr_bus_stb_i(stb[2]), .spr_bus_we_i(we[2]),
      .spr_bus_addr_i(addr[2]), .spr_bus_dat_i(wd[2]), .spr_bus_dat_o(dat_w[2]),
      .spr_bus_ack_o(ack_w[2]), .spr_cfg_i(cfg), .aesr_set_i(aset),
      .spr_evbar_o(evbar_w[2]), .spr_aecr_o(aecr_w[2]), .spr_aesr_o(aesr_w[2])
   );

   // Model: each claimed access is a record with the cycle number its ack must appear in.
   int unsigned cyc = 0;
   bit          busy [NI];
   int unsigned ack_at [NI];
   bit          p_we [NI];
   int          p_idx [NI];
   logic [31:0] p_wd [NI];
   logic [31:0] m_dat [NI];
   logic [31:0] m_evbar [NI];
   logic [6:0]  m_aecr [NI];
   logic [6:0]  m_aesr [NI];

   function automatic logic [31:0] model_read(input int i, input int idx);
      if (idx <= 10) return cfg[idx*32 +: 32];
      if (!FEAT[i]) return 32'h0;
      if (idx == 11) return m_evbar[i];
      if (idx == 12) return {25'h0, m_aecr[i]};
      if (idx == 13) return {25'h0, m_aesr[i]};
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         busy[i] = 1'b0; ack_at[i] = 0; m_dat[i] = '0;
         m_evbar[i] = '0; m_aecr[i] = '0; m_aesr[i] = '0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         bit ending;
         bit aesr_written;
         ending = busy[i] && (ack_at[i] == cyc);
         aesr_written = 1'b0;
         if (!busy[i] && stb[i] && addr[i][15:11] == 5'd0) begin
            busy[i] = 1'b1; ack_at[i] = cyc + 1 + WS[i];
            p_we[i] = we[i]; p_idx[i] = int'(addr[i][10:0]); p_wd[i] = wd[i];
         end
         if (busy[i] && ack_at[i] == cyc + 1) m_dat[i] = model_read(i, p_idx[i]);
         if (ending) begin
            busy[i] = 1'b0;
            if (p_we[i] && FEAT[i]) begin
               if (p_idx[i] == 11) m_evbar[i] = {p_wd[i][31:13], 13'h0};
               if (p_idx[i] == 12) m_aecr[i] = p_wd[i][6:0];
               if (p_idx[i] == 13) begin
                  m_aesr[i] = p_wd[i][6:0] | aset;
                  aesr_written = 1'b1;
               end
            end
         end
         if (FEAT[i] && !aesr_written) m_aesr[i] = m_aesr[i] | aset;
      end
      cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_edge();
      end
   end

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] at t=%0t: got %h, required %h", name, i, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, half a cycle away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            bit exp_ack;
            exp_ack = busy[i] && (ack_at[i] == cyc) && !rst;
            chk("ack", i, 32'(ack_w[i]), 32'(exp_ack));
            chk("dat", i, dat_w[i], exp_ack ? m_dat[i] : 32'h0);
            chk("evbar", i, evbar_w[i], m_evbar[i]);
            chk("aecr", i, 32'(aecr_w[i]), 32'(m_aecr[i]));
            chk("aesr", i, 32'(aesr_w[i]), 32'(m_aesr[i]));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic access(input int i, input bit w, input logic [15:0] a, input logic [31:0] d,
                         input logic [6:0] ack_set, input bit keep,
                         output logic [31:0] rd, output int lat);
      stb[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
      rd = '0;
      lat = 0;
      for (int n = 0; n < 40; n++) begin
         step();
         lat++;
         if (ack_w[i]) break;
      end
      if (!ack_w[i]) begin
         total++; bad++;
         $display("FAIL ack_timeout[%0d]: got no ack, required ack within 40 cycles", i);
      end
      rd = dat_w[i];
      aset = ack_set;
      if (!keep) begin
         stb[i] = 1'b0; we[i] = 1'b0;
         step();
         aset = '0;
      end
   endtask

   logic [31:0] rd;
   int          lat;
   int          nack;

   initial begin
      for (int i = 0; i < NI; i++) begin
         stb[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
      end
      aset = '0;
      for (int k = 0; k < 11; k++) cfg[k*32 +: 32] = 32'hC0DE_0000 | (32'(k) * 32'h111);
      cfg[31:0] = 32'h0000_0010;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_evbar", 0, evbar_w[0], 32'h0);
      chk("rst_ack", 0, 32'(ack_w[0]), 32'h0);
      chk("rst_aesr", 1, 32'(aesr_w[1]), 32'h0);

      // Read VR with zero wait states
      access(0, 1'b0, 16'h0000, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("vr_read", 0, rd, 32'h0000_0010);
      chk("lat_ws0", 0, 32'(lat), 32'd1);
      chk("ack_drop", 0, 32'(ack_w[0]), 32'h0);

      // EVBAR write keeps only [31:13]
      access(0, 1'b1, 16'h000B, 32'hDEAD_BEEF, 7'h0, 1'b0, rd, lat);
      chk("evbar_out", 0, evbar_w[0], 32'hDEAD_A000);
      access(0, 1'b0, 16'h000B, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("evbar_read", 0, rd, 32'hDEAD_A000);

      // AESR sticky set, then SW write racing a hardware set
      aset = 7'h04;
      step();
      aset = 7'h00;
      chk("aesr_sticky", 0, 32'(aesr_w[0]), 32'h04);
      access(0, 1'b1, 16'h000D, 32'h0000_0001, 7'h10, 1'b0, rd, lat);
      chk("aesr_race", 0, 32'(aesr_w[0]), 32'h11);
      chk("aesr_other", 1, 32'(aesr_w[1]), 32'h14);
      access(0, 1'b0, 16'h000D, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("aesr_read", 0, rd, 32'h11);
      access(0, 1'b1, 16'h000C, 32'hFFFF_FF5A, 7'h0, 1'b0, rd, lat);
      access(0, 1'b0, 16'h000C, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("aecr_read", 0, rd, 32'h5A);
      access(0, 1'b0, 16'h000E, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("unmapped", 0, rd, 32'h0);
      access(0, 1'b0, 16'h07FF, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("unmapped_top", 0, rd, 32'h0);

      // Three wait states; foreign group is never acked
      access(1, 1'b0, 16'h0002, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("cpucfgr_read", 1, rd, 32'hC0DE_0222);
      chk("lat_ws3", 1, 32'(lat), 32'd4);
      stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0800;
      nack = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (ack_w[1]) nack++;
      end
      stb[1] = 1'b0;
      chk("group1_acks", 1, 32'(nack), 32'h0);

      // Features absent: registers read 0 and ignore writes
      access(2, 1'b0, 16'h000A, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("avr_read", 2, rd, 32'hC0DE_0AAA);
      chk("lat_ws1", 2, 32'(lat), 32'd2);
      access(2, 1'b1, 16'h000B, 32'hDEAD_BEEF, 7'h0, 1'b0, rd, lat);
      access(2, 1'b0, 16'h000B, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("noevbar_read", 2, rd, 32'h0);
      chk("noevbar_out", 2, evbar_w[2], 32'h0);

      // Back-to-back: read VR2, write UPR, then UPR still reads the input
      access(0, 1'b0, 16'h0009, 32'h0, 7'h0, 1'b1, rd, lat);
      chk("vr2_read", 0, rd, 32'hC0DE_0999);
      access(0, 1'b1, 16'h0001, 32'hFFFF_FFFF, 7'h0, 1'b0, rd, lat);
      chk("b2b_lat", 0, 32'(lat), 32'd2);
      access(0, 1'b0, 16'h0001, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("upr_read", 0, rd, 32'hC0DE_0111);

      // Reset during the wait phase of an AECR write
      stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h000C; wd[1] = 32'h0000_007F;
      step();
      rst = 1'b1;
      #1;
      chk("rst_mid_ack", 1, 32'(ack_w[1]), 32'h0);
      step();
      stb[1] = 1'b0; we[1] = 1'b0;
      rst = 1'b0;
      nack = 0;
      for (int n = 0; n < 8; n++) begin
         step();
         if (ack_w[1]) nack++;
      end
      chk("rst_no_ack", 1, 32'(nack), 32'h0);
      chk("rst_aecr", 1, 32'(aecr_w[1]), 32'h0);
      chk("rst_evbar0", 0, evbar_w[0], 32'h0);
      access(1, 1'b0, 16'h000C, 32'h0, 7'h0, 1'b0, rd, lat);
      chk("aecr_after_rst", 1, rd, 32'h0);

      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
